// File: rtl/cpu_pkg.sv
// Shared types for the control sequencer: FSM states, opcode constants,
// IR field positions and the instruction-class decode.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_e;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_AND  = 5'b00101;
    localparam opcode_t OP_OR   = 5'b00110;
    localparam opcode_t OP_ROR  = 5'b00111;
    localparam opcode_t OP_ROL  = 5'b01000;
    localparam opcode_t OP_SHR  = 5'b01001;
    localparam opcode_t OP_SHRA = 5'b01010;
    localparam opcode_t OP_SHL  = 5'b01011;
    localparam opcode_t OP_MUL  = 5'b01111;
    localparam opcode_t OP_DIV  = 5'b10000;
    localparam opcode_t OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } iclass_e;

    function automatic iclass_e decode_class(opcode_t op);
        iclass_e cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = CLS_ALU;
            OP_MUL, OP_DIV:                  cls = CLS_MULDIV;
            OP_NOP:                          cls = CLS_NOP;
            OP_HALT:                         cls = CLS_HALT;
            default:                         cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath control bundle: IR feedback, memory ready and all
// register/bus/ALU strobes.
interface control_sequencer_if;

    logic [31:0] ir;
    logic        mem_ready;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic        PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin;
    logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
    logic [4:0]  opcode;

    modport master (
        input  ir, mem_ready,
        output reg_in, reg_out, PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin,
               Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, opcode
    );

    modport slave (
        output ir, mem_ready,
        input  reg_in, reg_out, PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin,
               Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, opcode
    );

endinterface

// File: rtl/control_sequencer_reg_select.sv
// 4-to-16 one-hot register select, forced to zero when not enabled.
module reg_select (
    input  logic [3:0]  sel_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);

    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    always_comb begin
        onehot_o = '0;
        if (en_i) onehot_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) and execute (T3-T6) state machine
// driving the datapath strobes; outputs depend only on registered state and IR.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    control_sequencer_if.master bus,
    output logic                halted,
    output logic                illegal,
    output logic                mem_timeout
);

    localparam logic [3:0] WAIT_LIMIT = (MEM_WAIT_MAX > 15) ? 4'hF : 4'(MEM_WAIT_MAX);

    state_e     state_q, state_d;
    logic [3:0] stall_q, stall_d;
    logic       timeout_seen_q, timeout_seen_d;

    opcode_t    op;
    iclass_e    iclass;
    logic [3:0] ra, rb, rc;
    logic [3:0] out_sel, in_sel;
    logic       out_en, in_en;
    logic [15:0] reg_out_w, reg_in_w;
    logic       unused_ir;

    assign op        = bus.ir[IR_OP_MSB:IR_OP_LSB];
    assign ra        = bus.ir[IR_RA_MSB:IR_RA_LSB];
    assign rb        = bus.ir[IR_RB_MSB:IR_RB_LSB];
    assign rc        = bus.ir[IR_RC_MSB:IR_RC_LSB];
    assign iclass    = decode_class(op);
    assign unused_ir = ^bus.ir[IR_RC_LSB-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q        <= S_IDLE;
            stall_q        <= '0;
            timeout_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_q        <= stall_d;
            timeout_seen_q <= timeout_seen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (bus.mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                case (iclass)
                    CLS_ALU, CLS_MULDIV: state_d = S_T4;
                    CLS_HALT:            state_d = S_HALT;
                    default:             state_d = run ? S_T0 : S_IDLE;
                endcase
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (iclass == CLS_MULDIV) ? S_T6 : (run ? S_T0 : S_IDLE);
            S_T6:   state_d = run ? S_T0 : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Counter is held at zero outside T1, so each fetch starts its stall count fresh.
    always_comb begin
        stall_d        = '0;
        timeout_seen_d = 1'b0;
        if (state_q == S_T1) begin
            stall_d        = (!bus.mem_ready && stall_q != 4'hF) ? stall_q + 4'd1 : stall_q;
            timeout_seen_d = timeout_seen_q | mem_timeout;
        end
    end

    always_comb begin
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.incPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.read     = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.ZLowOut  = 1'b0;
        bus.ZHighOut = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.opcode   = OP_NOP;
        out_en       = 1'b0;
        out_sel      = '0;
        in_en        = 1'b0;
        in_sel       = '0;
        halted       = 1'b0;
        illegal      = 1'b0;
        mem_timeout  = 1'b0;
        unique case (state_q)
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.incPC = 1'b1;
            end
            S_T1: begin
                bus.read    = 1'b1;
                bus.MDRin   = 1'b1;
                bus.PCin    = 1'b1;
                mem_timeout = (stall_q == WAIT_LIMIT) && !timeout_seen_q;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                illegal = (iclass == CLS_ILLEGAL);
                if (iclass == CLS_ALU || iclass == CLS_MULDIV) begin
                    bus.Yin = 1'b1;
                    out_en  = 1'b1;
                    out_sel = (iclass == CLS_ALU) ? rb : ra;
                end
            end
            S_T4: begin
                bus.Zin    = 1'b1;
                bus.opcode = op;
                out_en     = 1'b1;
                out_sel    = (iclass == CLS_ALU) ? rc : rb;
            end
            S_T5: begin
                bus.ZLowOut = 1'b1;
                if (iclass == CLS_MULDIV) begin
                    bus.LOin = 1'b1;
                end else begin
                    in_en  = 1'b1;
                    in_sel = ra;
                end
            end
            S_T6: begin
                bus.ZHighOut = 1'b1;
                bus.HIin     = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    reg_select u_out_sel (
        .sel_i    (out_sel),
        .en_i     (out_en),
        .onehot_o (reg_out_w)
    );

    reg_select u_in_sel (
        .sel_i    (in_sel),
        .en_i     (in_en),
        .onehot_o (reg_in_w)
    );

    assign bus.reg_out = reg_out_w;
    assign bus.reg_in  = reg_in_w;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: an instruction-level trace model
// queues the expected outputs for every cycle and one process compares them.
module tb_control_sequencer;

    localparam int          WAIT_MAX = 15;
    localparam logic [4:0]  OPC_NOP  = 5'b11010;

    localparam logic [13:0] M_PCOUT  = 14'h0001;
    localparam logic [13:0] M_PCIN   = 14'h0002;
    localparam logic [13:0] M_INCPC  = 14'h0004;
    localparam logic [13:0] M_MARIN  = 14'h0008;
    localparam logic [13:0] M_MDRIN  = 14'h0010;
    localparam logic [13:0] M_MDROUT = 14'h0020;
    localparam logic [13:0] M_READ   = 14'h0040;
    localparam logic [13:0] M_IRIN   = 14'h0080;
    localparam logic [13:0] M_YIN    = 14'h0100;
    localparam logic [13:0] M_ZIN    = 14'h0200;
    localparam logic [13:0] M_ZLO    = 14'h0400;
    localparam logic [13:0] M_ZHI    = 14'h0800;
    localparam logic [13:0] M_HIIN   = 14'h1000;
    localparam logic [13:0] M_LOIN   = 14'h2000;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [13:0] strb;
        logic [4:0]  opc;
        logic        halted;
        logic        illegal;
        logic        tmo;
    } out_t;

    logic clock = 1'b0;
    logic clear = 1'b0;
    logic run   = 1'b0;
    logic halted, illegal, mem_timeout;

    int   checks   = 0;
    int   failures = 0;
    out_t  exp_q[$];
    string tag_q[$];

    control_sequencer_if bus ();

    control_sequencer #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clock       (clock),
        .clear       (clear),
        .run         (run),
        .bus         (bus),
        .halted      (halted),
        .illegal     (illegal),
        .mem_timeout (mem_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t mk(logic [13:0] strb, logic [15:0] rout, logic [15:0] rin, logic [4:0] opc);
        out_t v;
        v      = '0;
        v.strb = strb;
        v.rout = rout;
        v.rin  = rin;
        v.opc  = opc;
        return v;
    endfunction

    function automatic logic [15:0] hot(logic [3:0] r);
        return 16'h0001 << r;
    endfunction

    function automatic logic [31:0] mk_ir(logic [4:0] op, logic [3:0] ra, logic [3:0] rb, logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    function automatic out_t sample();
        out_t v;
        v.rin     = bus.reg_in;
        v.rout    = bus.reg_out;
        v.strb    = {bus.LOin, bus.HIin, bus.ZHighOut, bus.ZLowOut, bus.Zin, bus.Yin, bus.IRin,
                     bus.read, bus.MDRout, bus.MDRin, bus.MARin, bus.incPC, bus.PCin, bus.PCout};
        v.opc     = bus.opcode;
        v.halted  = halted;
        v.illegal = illegal;
        v.tmo     = mem_timeout;
        return v;
    endfunction

    // Number of execute cycles an instruction occupies after its fetch.
    function automatic int exec_len(logic [31:0] instr);
        logic [4:0] op;
        op = instr[31:27];
        if (op >= 5'd3 && op <= 5'd11) return 3;
        if (op == 5'd15 || op == 5'd16) return 4;
        return 1;
    endfunction

    function automatic out_t exec_vec(logic [31:0] instr, int k);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        out_t v;
        op = instr[31:27];
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        v  = mk(14'h0, 16'h0, 16'h0, OPC_NOP);
        if (op >= 5'd3 && op <= 5'd11) begin
            case (k)
                0:       v = mk(M_YIN, hot(rb), 16'h0, OPC_NOP);
                1:       v = mk(M_ZIN, hot(rc), 16'h0, op);
                default: v = mk(M_ZLO, 16'h0, hot(ra), OPC_NOP);
            endcase
        end else if (op == 5'd15 || op == 5'd16) begin
            case (k)
                0:       v = mk(M_YIN, hot(ra), 16'h0, OPC_NOP);
                1:       v = mk(M_ZIN, hot(rb), 16'h0, op);
                2:       v = mk(M_ZLO | M_LOIN, 16'h0, 16'h0, OPC_NOP);
                default: v = mk(M_ZHI | M_HIIN, 16'h0, 16'h0, OPC_NOP);
            endcase
        end else if (op != OPC_NOP && op != 5'd27) begin
            v.illegal = 1'b1;
        end
        return v;
    endfunction

    task automatic cycle(input out_t e, input logic mr, input logic rn, input string tag);
        @(posedge clock);
        #1;
        bus.mem_ready = mr;
        run           = rn;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Caller guarantees the sequencer enters T0 on the next edge; abort_after >= 0
    // stops after that execute step so a reset can be dropped in mid-instruction.
    task automatic run_instr(input logic [31:0] instr, input int stalls, input logic rn,
                             input int abort_after);
        out_t v;
        int   n;
        cycle(mk(M_PCOUT | M_MARIN | M_INCPC, 16'h0, 16'h0, OPC_NOP), 1'b0, rn, "T0");
        bus.ir = instr;
        for (int i = 0; i <= stalls; i++) begin
            v     = mk(M_READ | M_MDRIN | M_PCIN, 16'h0, 16'h0, OPC_NOP);
            v.tmo = (i == WAIT_MAX);
            cycle(v, (i == stalls), rn, $sformatf("T1_wait%0d", i));
        end
        cycle(mk(M_MDROUT | M_IRIN, 16'h0, 16'h0, OPC_NOP), 1'b1, rn, "T2");
        n = (abort_after >= 0) ? abort_after + 1 : exec_len(instr);
        for (int k = 0; k < n; k++)
            cycle(exec_vec(instr, k), 1'b1, rn, $sformatf("exec%0d_op%b", k, instr[31:27]));
    endtask

    task automatic async_reset(input string name);
        out_t idle_v;
        idle_v = mk(14'h0, 16'h0, 16'h0, OPC_NOP);
        @(negedge clock);
        #2;
        run   = 1'b0;
        clear = 1'b0;
        #1;
        check(name, 64'(sample()), 64'(idle_v));
        @(posedge clock);
        #1;
        check({name, "_held"}, 64'(sample()), 64'(idle_v));
        @(negedge clock);
        #1;
        clear = 1'b1;
    endtask

    initial begin : compare
        out_t  e;
        string t;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check($sformatf("%s@%0t", t, $time), 64'(sample()), 64'(e));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin : stimulus
        out_t        idle_v, halt_v;
        logic [31:0] add_ir, mul_ir, ill_ir;
        idle_v = mk(14'h0, 16'h0, 16'h0, OPC_NOP);
        halt_v = idle_v;
        halt_v.halted = 1'b1;
        add_ir = 32'h1BA18000;
        mul_ir = mk_ir(5'b01111, 4'd2, 4'd5, 4'd0);
        ill_ir = mk_ir(5'b11111, 4'd9, 4'd1, 4'd2);
        bus.ir        = 32'h0;
        bus.mem_ready = 1'b0;

        // Hand-derived values pinning the trace model.
        check("pin_add_t3_rout", 64'(exec_vec(add_ir, 0).rout), 64'h0010);
        check("pin_add_t4_rout", 64'(exec_vec(add_ir, 1).rout), 64'h0008);
        check("pin_add_t4_opc",  64'(exec_vec(add_ir, 1).opc),  64'h03);
        check("pin_add_t5_rin",  64'(exec_vec(add_ir, 2).rin),  64'h0080);
        check("pin_add_len",     64'(3 + exec_len(add_ir)),    64'd6);
        check("pin_mul_len",     64'(3 + exec_len(mul_ir)),    64'd7);
        check("pin_mul_t6_strb", 64'(exec_vec(mul_ir, 3).strb), 64'h1800);
        check("pin_ill_flag",    64'({exec_vec(ill_ir, 0).illegal, exec_vec(ill_ir, 0).rin}), 64'h10000);

        #12;
        check("reset_outputs", 64'(sample()), 64'(idle_v));
        @(negedge clock);
        #1;
        clear = 1'b1;

        for (int i = 0; i < 5; i++) cycle(idle_v, 1'b0, 1'b0, "idle_after_reset");
        cycle(idle_v, 1'b0, 1'b1, "idle_run");

        run_instr(add_ir, 0, 1'b1, -1);
        run_instr(mul_ir, 0, 1'b1, -1);
        run_instr(mk_ir(5'b00011, 4'd4, 4'd4, 4'd4), 3, 1'b1, -1);
        run_instr(mk_ir(5'b10000, 4'd15, 4'd0, 4'd14), 1, 1'b1, -1);
        run_instr(mk_ir(5'b11010, 4'd3, 4'd3, 4'd3), 0, 1'b1, -1);
        run_instr(ill_ir, 0, 1'b1, -1);
        run_instr(mk_ir(5'b00100, 4'd1, 4'd9, 4'd6), 0, 1'b1, -1);
        run_instr(mk_ir(5'b01011, 4'd0, 4'd15, 4'd15), 20, 1'b0, -1);
        for (int i = 0; i < 3; i++) cycle(idle_v, 1'b0, 1'b0, "idle_run_low");
        cycle(idle_v, 1'b0, 1'b1, "idle_run_again");
        run_instr(mk_ir(5'b00111, 4'd3, 4'd2, 4'd1), 0, 1'b1, -1);

        run_instr(mk_ir(5'b11011, 4'd0, 4'd0, 4'd0), 0, 1'b1, -1);
        for (int i = 0; i < 5; i++) cycle(halt_v, 1'b1, 1'b1, "halted");
        async_reset("reset_from_halt");

        cycle(idle_v, 1'b0, 1'b1, "idle_after_halt");
        run_instr(add_ir, 0, 1'b1, 1);
        async_reset("reset_in_t4");

        cycle(idle_v, 1'b0, 1'b1, "idle_after_abort");
        run_instr(mk_ir(5'b00101, 4'd12, 4'd10, 4'd11), 2, 1'b0, -1);
        cycle(idle_v, 1'b0, 1'b0, "idle_final");
        cycle(idle_v, 1'b0, 1'b0, "idle_final");

        @(negedge clock);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
